// File: rtl/atmega_pio_pcint.sv
// AVR-style parallel I/O port with pin-change interrupt.
// Holds PORT/DDR registers, synchronises the pin inputs and latches
// rising/falling pin events into a write-1-to-clear flag register (PCIF)
// whose OR drives the interrupt line.
module atmega_pio_pcint #(
   parameter                               PLATFORM          = "XILINX",
   parameter int                           BUS_ADDR_DATA_LEN = 8,
   parameter int                           PORT_WIDTH        = 8,
   parameter int                           SYNC_STAGES       = 2,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] PORT_OUT_ADDR     = 'h20,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] PORT_CLEAR_ADDR   = 'h00,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] PORT_SET_ADDR     = 'h01,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] DDR_ADDR          = 'h23,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] PIN_ADDR          = 'h24,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] RISE_EN_ADDR      = 'h25,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] FALL_EN_ADDR      = 'h26,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] PCIF_ADDR         = 'h27,
   parameter logic [PORT_WIDTH-1:0]        PINMASK           = '1,
   parameter logic [PORT_WIDTH-1:0]        INVERSE_MASK      = '0,
   parameter logic [PORT_WIDTH-1:0]        OUT_ENABLED_MASK  = '1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
   input  logic                         wr_dat,
   input  logic                         rd_dat,
   input  logic [PORT_WIDTH-1:0]        bus_dat_in,
   output logic [PORT_WIDTH-1:0]        bus_dat_out,
   input  logic [PORT_WIDTH-1:0]        io_in,
   output logic [PORT_WIDTH-1:0]        io_out,
   output logic [PORT_WIDTH-1:0]        pio_out_io_connect,
   output logic                         irq
);

   // Elaboration-time guard on the supported parameter ranges.
   if (PORT_WIDTH < 1 || PORT_WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
       $bits(PLATFORM) == 0) begin : g_bad_params
      $error("atmega_pio_pcint: unsupported parameter value");
   end

   // Detection stays off until the synchroniser and PIN_d hold real samples.
   localparam int ARM_COUNT = SYNC_STAGES + 1;

   logic [PORT_WIDTH-1:0]                  r_port;
   logic [PORT_WIDTH-1:0]                  r_ddr;
   logic [PORT_WIDTH-1:0]                  r_rise_en;
   logic [PORT_WIDTH-1:0]                  r_fall_en;
   logic [PORT_WIDTH-1:0]                  r_pcif;
   logic [PORT_WIDTH-1:0]                  r_pin_d;
   logic [SYNC_STAGES-1:0][PORT_WIDTH-1:0] r_sync;
   logic [2:0]                             r_arm_cnt;

   logic [PORT_WIDTH-1:0] w_pin;
   logic                  w_armed;
   logic [PORT_WIDTH-1:0] w_event;
   logic [PORT_WIDTH-1:0] w_wr_data;
   logic [PORT_WIDTH-1:0] w_pcif_clr;
   logic [PORT_WIDTH-1:0] w_out_en;
   logic [PORT_WIDTH-1:0] w_out_val;
   logic                  w_wr_port_out;
   logic                  w_wr_port_clr;
   logic                  w_wr_port_set;
   logic                  w_wr_port_tgl;
   logic                  w_wr_ddr;
   logic                  w_wr_rise;
   logic                  w_wr_fall;
   logic                  w_wr_pcif;

   assign w_pin     = r_sync[SYNC_STAGES-1];
   assign w_armed   = (r_arm_cnt == ARM_COUNT[2:0]);
   // Edge detection works on the raw (non-inverted) pin level.
   assign w_event   = ((w_pin & ~r_pin_d & r_rise_en) | (~w_pin & r_pin_d & r_fall_en)) &
                      PINMASK & {PORT_WIDTH{w_armed}};
   // Masked-out pins never accept write data, so stored bits stay 0 there.
   assign w_wr_data = bus_dat_in & PINMASK;

   assign w_wr_port_out = wr_dat && (addr_dat == PORT_OUT_ADDR);
   assign w_wr_port_clr = wr_dat && (addr_dat == PORT_CLEAR_ADDR);
   assign w_wr_port_set = wr_dat && (addr_dat == PORT_SET_ADDR);
   assign w_wr_port_tgl = wr_dat && (addr_dat == PIN_ADDR);
   assign w_wr_ddr      = wr_dat && (addr_dat == DDR_ADDR);
   assign w_wr_rise     = wr_dat && (addr_dat == RISE_EN_ADDR);
   assign w_wr_fall     = wr_dat && (addr_dat == FALL_EN_ADDR);
   assign w_wr_pcif     = wr_dat && (addr_dat == PCIF_ADDR);
   assign w_pcif_clr    = w_wr_pcif ? w_wr_data : '0;

   // Input synchroniser chain and one-clock delayed PIN copy for edge detect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync  <= '0;
         r_pin_d <= '0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], io_in};
         r_pin_d <= w_pin;
      end
   end

   // Arm counter: counts clocks after reset release and saturates once armed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_arm_cnt <= '0;
      end else if (!w_armed) begin
         r_arm_cnt <= r_arm_cnt + 3'd1;
      end
   end

   // PORT register: load, clear-bits, set-bits and toggle-via-PIN writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_port <= '0;
      end else if (w_wr_port_out) begin
         r_port <= w_wr_data;
      end else if (w_wr_port_clr) begin
         r_port <= r_port & ~w_wr_data;
      end else if (w_wr_port_set) begin
         r_port <= r_port | w_wr_data;
      end else if (w_wr_port_tgl) begin
         r_port <= r_port ^ w_wr_data;
      end
   end

   // Direction and edge-enable configuration registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ddr     <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
      end else begin
         if (w_wr_ddr)  r_ddr     <= w_wr_data;
         if (w_wr_rise) r_rise_en <= w_wr_data;
         if (w_wr_fall) r_fall_en <= w_wr_data;
      end
   end

   // Pin-change flags: write-1-to-clear, a same-cycle event overrides the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pcif <= '0;
      end else begin
         r_pcif <= (r_pcif & ~w_pcif_clr) | w_event;
      end
   end

   // Combinational read mux; CLEAR/SET and unknown addresses read as zero.
   always_comb begin
      bus_dat_out = '0;
      if (rd_dat && rst) begin
         if (addr_dat == PORT_OUT_ADDR) begin
            bus_dat_out = r_port;
         end else if (addr_dat == DDR_ADDR) begin
            bus_dat_out = r_ddr;
         end else if (addr_dat == PIN_ADDR) begin
            bus_dat_out = (w_pin ^ INVERSE_MASK) & PINMASK;
         end else if (addr_dat == RISE_EN_ADDR) begin
            bus_dat_out = r_rise_en;
         end else if (addr_dat == FALL_EN_ADDR) begin
            bus_dat_out = r_fall_en;
         end else if (addr_dat == PCIF_ADDR) begin
            bus_dat_out = r_pcif;
         end
      end
   end

   assign w_out_en           = r_ddr & PINMASK & OUT_ENABLED_MASK;
   assign w_out_val          = r_port ^ INVERSE_MASK;
   assign pio_out_io_connect = w_out_en;
   assign irq                = |r_pcif;

   for (genvar g = 0; g < PORT_WIDTH; g++) begin : g_pad
      assign io_out[g] = w_out_en[g] ? w_out_val[g] : 1'bz;
   end

endmodule

// File: doc/atmega_pio_pcint.md
ATMEGA_PIO_PCINT -- requirements
Module: atmega_pio_pcint

Interface
REQ-001 SHALL have parameter PLATFORM, default "XILINX", target family tag (informational only; no primitives instantiated).
REQ-002 SHALL have parameter BUS_ADDR_DATA_LEN, default 8, width of addr_dat.
REQ-003 SHALL have parameter PORT_WIDTH, default 8, pin count and bus data width (1..32).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (2..4).
REQ-005 SHALL have address parameters PORT_OUT_ADDR 'h20, PORT_CLEAR_ADDR 'h00, PORT_SET_ADDR 'h01, DDR_ADDR 'h23, PIN_ADDR 'h24, RISE_EN_ADDR 'h25, FALL_EN_ADDR 'h26, PCIF_ADDR 'h27, all distinct, full-width compare.
REQ-006 SHALL have masks PINMASK all-ones, INVERSE_MASK 0, OUT_ENABLED_MASK all-ones, each PORT_WIDTH bits.
REQ-007 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-008 SHALL have: rst  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have: addr_dat  in  BUS_ADDR_DATA_LEN  register address; wr_dat  in  1  write strobe; rd_dat  in  1  read strobe.
REQ-010 SHALL have: bus_dat_in  in  PORT_WIDTH  write data; bus_dat_out  out  PORT_WIDTH  read data.
REQ-011 SHALL have: io_in  in  PORT_WIDTH  asynchronous pin inputs; io_out  out  PORT_WIDTH  tri-state pin drive; pio_out_io_connect  out  PORT_WIDTH  per-pin output enable; irq  out  1  pin-change interrupt.

Function
REQ-012 Bits with PINMASK=0 SHALL read 0, ignore writes, never set PCIF, drive io_out z and pio_out_io_connect 0.
REQ-013 io_in SHALL pass through a SYNC_STAGES-flop chain; PIN = last stage; io_in change before edge k appears in PIN after edge k+SYNC_STAGES-1.
REQ-014 Write PORT_OUT_ADDR: PORT<=data; PORT_CLEAR_ADDR: PORT<=PORT&~data; PORT_SET_ADDR: PORT<=PORT|data; PIN_ADDR: PORT<=PORT^data (toggle); DDR/RISE_EN/FALL_EN addresses load respective register.
REQ-015 Write PCIF_ADDR SHALL clear each PCIF bit written 1 (write-1-to-clear); 0 bits unchanged.
REQ-016 Writes SHALL take effect on the clk edge where wr_dat=1; non-matching addresses ignored.
REQ-017 bus_dat_out SHALL be combinational: 0 when rd_dat=0 or rst=0 or no address match; else PORT, DDR, PIN^INVERSE_MASK, RISE_EN, FALL_EN or PCIF; CLEAR/SET addresses read 0.
REQ-018 Rising event bit i: PIN[i]=1, PIN_d[i]=0 (PIN_d = PIN delayed one clock) and RISE_EN[i]=1; falling symmetric with FALL_EN; detection on non-inverted PIN.
REQ-019 Event SHALL set PCIF[i] on the next clk edge (io_in change to PCIF set = SYNC_STAGES+1 edges).
REQ-020 Same-cycle event and write-1-clear on one bit: set SHALL win.
REQ-021 irq SHALL equal OR of PCIF, combinational from register, no extra latency.
REQ-022 Arm counter SHALL suppress event detection for SYNC_STAGES+1 clocks after reset release; counter saturates, armed until next reset.
REQ-023 io_out[i] = DDR[i] ? (PORT[i]^INVERSE_MASK[i]) : z, when PINMASK&OUT_ENABLED_MASK; else z; pio_out_io_connect[i] = DDR[i] under same mask, else 0.

Reset
REQ-024 rst=0 SHALL asynchronously clear PORT, DDR, RISE_EN, FALL_EN, PCIF, synchronizer, PIN, PIN_d and arm counter; irq=0, io_out all z, pio_out_io_connect 0.
REQ-025 Reset asserted mid-operation SHALL discard pending events; no PCIF set on the release edge.

Verification
REQ-026 Reset release with io_in='hFF, RISE_EN='hFF written immediately -> PIN reads 'hFF after SYNC_STAGES edges, PCIF stays 0, irq 0.
REQ-027 DDR='h0F, PORT='h05, write PIN_ADDR 'h03 -> PORT='h06, io_out low nibble 'h6, high nibble z, pio_out_io_connect='h0F.
REQ-028 RISE_EN='h01, io_in[0] 0->1 -> PCIF='h01 and irq=1 exactly SYNC_STAGES+1 edges later; write PCIF 'h01 -> irq 0 next cycle.
REQ-029 FALL_EN='h80, io_in[7] falls in the cycle PCIF 'h80 clear is written -> PCIF[7] remains 1.
REQ-030 INVERSE_MASK='h01, io_in[0]=1 -> PIN read bit0=0; PINMASK='h7F: write PORT 'hFF -> reads 'h7F, io_out[7] z.
